// File: rtl/instruction_fetch.sv
// Single-issue instruction fetch stage: PC register, one-entry output buffer, redirect/flush.
// Define FETCH_BOUND_CHECK_EN to trap fetches beyond IMEM_WORDS into a sticky FAULT state.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1501
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fault
);

`ifdef FETCH_BOUND_CHECK_EN
  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_t;
`else
  typedef enum logic [0:0] {ST_RUN = 1'b0} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic        valid_d;
  logic [31:0] instr_d, opc_d, op4_d;
  logic        can_issue;
  logic        issue;

  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + 32'd4;

  assign can_issue = (state_q == ST_RUN) && !redirect_valid && (!out_valid || out_ready);

`ifdef FETCH_BOUND_CHECK_EN
  logic out_of_range;
  logic fault_q, fault_d;

  assign out_of_range = ({2'b00, pc_q[31:2]} >= IMEM_WORDS);
  assign issue        = can_issue && !out_of_range;
  assign fault        = fault_q;
`else
  assign issue = can_issue;
  assign fault = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = out_valid && !out_ready;
    instr_d = out_instr;
    opc_d   = out_pc;
    op4_d   = out_pc_plus4;
`ifdef FETCH_BOUND_CHECK_EN
    fault_d = fault_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          pc_d    = {redirect_pc[31:2], 2'b00};
          valid_d = 1'b0;
        end else if (issue) begin
          instr_d = imem_rd;
          opc_d   = pc_q;
          op4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end
`ifdef FETCH_BOUND_CHECK_EN
        else if (can_issue) begin
          // Out-of-range fetch: nothing captured, PC frozen until reset.
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC & ~32'h3;
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_pc       <= '0;
      out_pc_plus4 <= '0;
`ifdef FETCH_BOUND_CHECK_EN
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      out_valid    <= valid_d;
      out_instr    <= instr_d;
      out_pc       <= opc_d;
      out_pc_plus4 <= op4_d;
`ifdef FETCH_BOUND_CHECK_EN
      fault_q      <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch; imem model returns word[i] = i + 1.
module tb_instruction_fetch;

  localparam int unsigned WORDS = 1501;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_rd = (imem_addr >> 2) + 32'd1;

  instruction_fetch #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(WORDS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rd       (imem_rd),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pc_plus4  (out_pc_plus4),
    .fault         (fault)
  );

  typedef struct {
    logic        rst_n;
    logic        rv;
    logic [31:0] rp;
    logic        rdy;
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        f;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic rv, input logic [31:0] rp, input logic rdy,
                     input logic v, input logic [31:0] pc, input logic [31:0] instr,
                     input logic [31:0] addr, input logic f);
    vec_t t;
    t = '{r, rv, rp, rdy, v, pc, instr, addr, f};
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    rst_n          = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 1'b1);

    //   rst  rv    rp            rdy   v     out_pc        instr         imem_addr     fault
    add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h1,        32'h4,        1'b0);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'h2,        32'h8,        1'b0);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        32'h3,        32'hC,        1'b0);
    add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h3,        32'hC,        1'b0);
    add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h3,        32'hC,        1'b0);
    add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h3,        32'hC,        1'b0);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        32'h4,        32'h10,       1'b0);
    add(1'b1, 1'b1, 32'h103,      1'b1, 1'b0, 32'hC,        32'h4,        32'h100,      1'b0);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      32'h41,       32'h104,      1'b0);
    add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h100,      32'h41,       32'h104,      1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0);
    add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h1,        32'h4,        1'b0);
    add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h1,        32'h4,        1'b0);
    add(1'b1, 1'b1, 32'h200,      1'b0, 1'b0, 32'h0,        32'h1,        32'h200,      1'b0);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h200,      32'h81,       32'h204,      1'b0);
    add(1'b1, 1'b1, 32'h12,       1'b1, 1'b0, 32'h200,      32'h81,       32'h10,       1'b0);
    add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       32'h5,        32'h14,       1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].rv, vecs[i].rp, vecs[i].rdy);
      step();
      check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].v});
      check($sformatf("v%0d out_pc", i), out_pc, vecs[i].pc);
      check($sformatf("v%0d out_instr", i), out_instr, vecs[i].instr);
      check($sformatf("v%0d out_pc_plus4", i), out_pc_plus4,
            vecs[i].rst_n ? vecs[i].pc + 32'd4 : 32'h0);
      check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].addr);
      check($sformatf("v%0d fault", i), {31'b0, fault}, {31'b0, vecs[i].f});
    end

`ifdef FETCH_BOUND_CHECK_EN
    // Last in-range word is 1500 (byte 0x1770); the next sequential fetch must trap.
    drive(1'b1, 1'b1, 32'h0000_1770, 1'b1);
    step();
    check("bound redirect addr", imem_addr, 32'h1770);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    step();
    check("bound last out_pc", out_pc, 32'h1770);
    check("bound last valid", {31'b0, out_valid}, 32'h1);
    check("bound last fault", {31'b0, fault}, 32'h0);
    step();
    check("bound trap fault", {31'b0, fault}, 32'h1);
    check("bound trap valid", {31'b0, out_valid}, 32'h0);
    check("bound trap addr", imem_addr, 32'h1774);
    check("bound trap out_pc", out_pc, 32'h1770);
    drive(1'b1, 1'b1, 32'h0, 1'b1);
    step();
    check("fault ignores redirect addr", imem_addr, 32'h1774);
    check("fault ignores redirect flag", {31'b0, fault}, 32'h1);
    check("fault no issue", {31'b0, out_valid}, 32'h0);
    drive(1'b0, 1'b1, 32'h40, 1'b1);
    step();
    check("fault reset flag", {31'b0, fault}, 32'h0);
    check("fault reset addr", imem_addr, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    step();
    check("fault reset resume pc", out_pc, 32'h0);
    check("fault reset resume valid", {31'b0, out_valid}, 32'h1);
`else
    // Wrap at the top of the address space; also checks low-bit masking of redirect_pc.
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    step();
    check("wrap redirect addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap redirect valid", {31'b0, out_valid}, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    step();
    check("wrap out_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap out_pc_plus4", out_pc_plus4, 32'h0);
    check("wrap out_instr", out_instr, 32'h4000_0000);
    check("wrap imem_addr", imem_addr, 32'h0);
    check("wrap fault tied", {31'b0, fault}, 32'h0);
    step();
    check("post-wrap out_pc", out_pc, 32'h0);
    check("post-wrap out_instr", out_instr, 32'h1);
`endif

    // Accepted entry with nothing to issue behind it (redirect blocks issue): valid drops.
    drive(1'b1, 1'b1, 32'h80, 1'b1);
    step();
    check("accept+redirect valid", {31'b0, out_valid}, 32'h0);
    check("accept+redirect addr", imem_addr, 32'h80);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    step();
    check("after flush out_pc", out_pc, 32'h80);
    check("after flush instr", out_instr, 32'h21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
